// File: rtl/neuron_sample_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neuron_sample_feeder_pkg
// Description : Shared FSM states, default widths and sample record for the
//               neuron trainer's sample feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package neuron_sample_feeder_pkg;

    localparam int c_X_W   = 7;
    localparam int c_T_W   = 2;
    localparam int c_DEPTH = 512;

    typedef enum logic [2:0] {
        LOAD     = 3'd0,
        WAIT_REQ = 3'd1,
        FETCH    = 3'd2,
        PRESENT  = 3'd3,
        DONE     = 3'd4
    } state_t;

    typedef struct packed {
        logic signed [c_X_W-1:0] x1;
        logic signed [c_X_W-1:0] x2;
        logic signed [c_T_W-1:0] t;
    } sample_t;

endpackage
`default_nettype wire

// File: rtl/neuron_sample_feeder_sample_ram.sv
`default_nettype none
// ============================================================================
// Module      : neuron_sample_feeder_sample_ram
// Description : Training-set store, one write port and one registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_sample_feeder_sample_ram #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // No reset: the loaded set survives rst, only the count is cleared.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/neuron_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module      : neuron_sample_feeder
// Description : Buffers (x1,x2,t) samples and streams them to the neuron epoch
//               after epoch. Optional macro FEEDER_EPOCH_LIMIT_EN adds timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_sample_feeder
    import neuron_sample_feeder_pkg::*;
#(
    parameter int X_W        = c_X_W,
    parameter int T_W        = c_T_W,
    parameter int DEPTH      = c_DEPTH,
    parameter int ADDR_W     = 9,
    parameter int CNT_W      = 32
`ifdef FEEDER_EPOCH_LIMIT_EN
    ,
    parameter int MAX_EPOCHS = 64
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [X_W-1:0]   wr_x1,
    input  logic [X_W-1:0]   wr_x2,
    input  logic [T_W-1:0]   wr_t,
    input  logic             start,
    input  logic             request,
    input  logic             neuron_done,
    output logic [X_W-1:0]   x1,
    output logic [X_W-1:0]   x2,
    output logic [T_W-1:0]   t,
    output logic             data_ready,
    output logic [CNT_W-1:0] n_samples,
    output logic [15:0]      epoch,
    output logic             overflow,
`ifdef FEEDER_EPOCH_LIMIT_EN
    output logic             timeout,
`endif
    output logic             busy
);

    localparam int c_DATA_W = 2*X_W + T_W;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_index;
    logic [CNT_W-1:0]    r_count;
    logic [15:0]         r_epoch;
    logic [X_W-1:0]      r_x1;
    logic [X_W-1:0]      r_x2;
    logic [T_W-1:0]      r_t;
    logic                r_data_ready;
    logic                r_overflow;
    logic                r_busy;
`ifdef FEEDER_EPOCH_LIMIT_EN
    logic                r_timeout;
`endif

    logic                w_full;
    logic                w_wr;
    logic [CNT_W-1:0]    w_count_next;
    logic                w_last;
    logic [15:0]         w_epoch_inc;
    logic [c_DATA_W-1:0] w_rdata;

    assign w_full       = (r_count >= CNT_W'(DEPTH));
    assign w_wr         = (r_state == LOAD) && wr_en && !w_full;
    assign w_count_next = r_count + CNT_W'(w_wr);
    assign w_last       = (CNT_W'(r_index) == (r_count - CNT_W'(1)));
    assign w_epoch_inc  = r_epoch + 16'd1;

    // The read port tracks r_index every cycle, so data is ready by the end of FETCH.
    neuron_sample_feeder_sample_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (c_DATA_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_count[ADDR_W-1:0]),
        .i_wdata ({wr_x1, wr_x2, wr_t}),
        .i_raddr (r_index),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= LOAD;
            r_index      <= '0;
            r_count      <= '0;
            r_epoch      <= '0;
            r_x1         <= '0;
            r_x2         <= '0;
            r_t          <= '0;
            r_data_ready <= 1'b0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b0;
`ifdef FEEDER_EPOCH_LIMIT_EN
            r_timeout    <= 1'b0;
`endif
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_wr) r_count <= w_count_next;
                    if (wr_en && w_full) r_overflow <= 1'b1;
                    if (start && (w_count_next != '0)) begin
                        r_state <= WAIT_REQ;
                        r_busy  <= 1'b1;
                        r_index <= '0;
                        r_epoch <= '0;
                    end
                end
                WAIT_REQ: begin
                    if (neuron_done) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                    end else if (request) begin
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    if (neuron_done) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state      <= PRESENT;
                        r_x1         <= w_rdata[c_DATA_W-1 -: X_W];
                        r_x2         <= w_rdata[T_W+X_W-1 -: X_W];
                        r_t          <= w_rdata[T_W-1:0];
                        r_data_ready <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (neuron_done) begin
                        r_state      <= DONE;
                        r_busy       <= 1'b0;
                        r_data_ready <= 1'b0;
                    end else if (!request) begin
                        r_state      <= WAIT_REQ;
                        r_data_ready <= 1'b0;
                        if (!w_last) begin
                            r_index <= r_index + ADDR_W'(1);
                        end else begin
                            r_index <= '0;
                            r_epoch <= w_epoch_inc;
`ifdef FEEDER_EPOCH_LIMIT_EN
                            if (w_epoch_inc == 16'(MAX_EPOCHS)) begin
                                r_state   <= DONE;
                                r_busy    <= 1'b0;
                                r_timeout <= 1'b1;
                            end
`endif
                        end
                    end
                end
                DONE: begin
                    if (start && !neuron_done) begin
                        r_state <= WAIT_REQ;
                        r_busy  <= 1'b1;
                        r_index <= '0;
                        r_epoch <= '0;
                    end
                end
                default: begin
                    r_state      <= LOAD;
                    r_busy       <= 1'b0;
                    r_data_ready <= 1'b0;
                end
            endcase
        end
    end

    assign x1         = r_x1;
    assign x2         = r_x2;
    assign t          = r_t;
    assign data_ready = r_data_ready;
    assign n_samples  = r_count;
    assign epoch      = r_epoch;
    assign overflow   = r_overflow;
    assign busy       = r_busy;
`ifdef FEEDER_EPOCH_LIMIT_EN
    assign timeout    = r_timeout;
`endif

endmodule
`default_nettype wire

// File: tb/tb_neuron_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_sample_feeder
// Description : Directed self-checking bench for neuron_sample_feeder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_sample_feeder;
    import neuron_sample_feeder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [6:0]  wr_x1 = '0;
    logic [6:0]  wr_x2 = '0;
    logic [1:0]  wr_t = '0;
    logic        start = 1'b0;
    logic        request = 1'b0;
    logic        neuron_done = 1'b0;
    logic [6:0]  x1;
    logic [6:0]  x2;
    logic [1:0]  t;
    logic        data_ready;
    logic [31:0] n_samples;
    logic [15:0] epoch;
    logic        overflow;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc;

    sample_t vec [3];
    sample_t one;

    always #5 clk = ~clk;

`ifdef FEEDER_EPOCH_LIMIT_EN
    logic timeout;
    neuron_sample_feeder #(.MAX_EPOCHS(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_x1(wr_x1), .wr_x2(wr_x2), .wr_t(wr_t),
        .start(start), .request(request), .neuron_done(neuron_done),
        .x1(x1), .x2(x2), .t(t), .data_ready(data_ready), .n_samples(n_samples),
        .epoch(epoch), .overflow(overflow), .timeout(timeout), .busy(busy)
    );
`else
    neuron_sample_feeder dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_x1(wr_x1), .wr_x2(wr_x2), .wr_t(wr_t),
        .start(start), .request(request), .neuron_done(neuron_done),
        .x1(x1), .x2(x2), .t(t), .data_ready(data_ready), .n_samples(n_samples),
        .epoch(epoch), .overflow(overflow), .busy(busy)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dr(output int n);
        n = 0;
        while (data_ready !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1; wr_en = 1'b0; start = 1'b0; request = 1'b0; neuron_done = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        tick();
        checks++; if ({data_ready, busy, overflow} !== 3'b000) begin failures++;
            $display("FAIL reset_flags got=%b exp=000", {data_ready, busy, overflow}); end
        checks++; if (n_samples !== 32'd0 || epoch !== 16'd0) begin failures++;
            $display("FAIL reset_counts n=%0d epoch=%0d exp=0/0", n_samples, epoch); end
        checks++; if ({x1, x2, t} !== 16'h0000) begin failures++;
            $display("FAIL reset_sample got=%h exp=0000", {x1, x2, t}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_first();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_x1 = vec[i].x1; wr_x2 = vec[i].x2; wr_t = vec[i].t;
            tick();
        end
        wr_en = 1'b0;
        checks++; if (n_samples !== 32'd3 || busy !== 1'b0) begin failures++;
            $display("FAIL load_count n=%0d busy=%b exp=3/0", n_samples, busy); end
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (busy !== 1'b1 || data_ready !== 1'b0) begin failures++;
            $display("FAIL start_busy busy=%b dr=%b exp=1/0", busy, data_ready); end
        request = 1'b1;
        tick();
        checks++; if (data_ready !== 1'b0) begin failures++;
            $display("FAIL first_latency1 dr=%b exp=0", data_ready); end
        tick();
        checks++; if (data_ready !== 1'b1) begin failures++;
            $display("FAIL first_latency2 dr=%b exp=1", data_ready); end
        checks++; if ({x1, x2, t} !== {vec[0].x1, vec[0].x2, vec[0].t}) begin failures++;
            $display("FAIL first_sample got=%h exp=%h", {x1, x2, t}, {vec[0].x1, vec[0].x2, vec[0].t}); end
    endtask

    task automatic test_stream();
        for (int k = 1; k <= 3; k++) begin
            request = 1'b0;
            tick();
            checks++; if (data_ready !== 1'b0) begin failures++;
                $display("FAIL stream_drop%0d dr=%b exp=0", k, data_ready); end
            checks++; if (epoch !== ((k == 3) ? 16'd1 : 16'd0)) begin failures++;
                $display("FAIL stream_epoch%0d got=%0d exp=%0d", k, epoch, (k == 3) ? 1 : 0); end
            checks++; if (x1 !== vec[k-1].x1) begin failures++;
                $display("FAIL stream_hold%0d x1=%h exp=%h", k, x1, vec[k-1].x1); end
            request = 1'b1;
            wait_dr(cyc);
            checks++; if (cyc != 2) begin failures++;
                $display("FAIL stream_latency%0d got=%0d exp=2", k, cyc); end
            checks++; if ({x1, x2, t} !== {vec[k%3].x1, vec[k%3].x2, vec[k%3].t}) begin failures++;
                $display("FAIL stream_sample%0d got=%h exp=%h", k, {x1, x2, t}, {vec[k%3].x1, vec[k%3].x2, vec[k%3].t}); end
        end
    endtask

    task automatic test_done();
        neuron_done = 1'b1;
        tick();
        checks++; if ({data_ready, busy} !== 2'b00 || epoch !== 16'd1) begin failures++;
            $display("FAIL done_entry dr=%b busy=%b epoch=%0d exp=0/0/1", data_ready, busy, epoch); end
        wr_en = 1'b1; tick(); wr_en = 1'b0; tick();
        checks++; if (n_samples !== 32'd3 || data_ready !== 1'b0 || x1 !== vec[0].x1) begin failures++;
            $display("FAIL done_hold n=%0d dr=%b x1=%h exp=3/0/%h", n_samples, data_ready, x1, vec[0].x1); end
        neuron_done = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (epoch !== 16'd0 || busy !== 1'b1) begin failures++;
            $display("FAIL restart epoch=%0d busy=%b exp=0/1", epoch, busy); end
        wait_dr(cyc);
        checks++; if (cyc != 2 || {x1, x2, t} !== {vec[0].x1, vec[0].x2, vec[0].t}) begin failures++;
            $display("FAIL restart_sample cyc=%0d got=%h exp=2/%h", cyc, {x1, x2, t}, {vec[0].x1, vec[0].x2, vec[0].t}); end
    endtask

    task automatic test_async_rst();
        #2 rst = 1'b1;
        #1;
        checks++; if ({data_ready, busy} !== 2'b00 || n_samples !== 32'd0 || epoch !== 16'd0) begin failures++;
            $display("FAIL async_rst dr=%b busy=%b n=%0d epoch=%0d exp=0/0/0/0", data_ready, busy, n_samples, epoch); end
        request = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_same_cycle_start();
        wr_en = 1'b1; start = 1'b1; wr_x1 = one.x1; wr_x2 = one.x2; wr_t = one.t;
        tick();
        wr_en = 1'b0; start = 1'b0;
        checks++; if (n_samples !== 32'd1 || busy !== 1'b1) begin failures++;
            $display("FAIL wr_start n=%0d busy=%b exp=1/1", n_samples, busy); end
        request = 1'b1;
        wait_dr(cyc);
        checks++; if (cyc != 2 || {x1, x2, t} !== {one.x1, one.x2, one.t}) begin failures++;
            $display("FAIL single_sample cyc=%0d got=%h exp=2/%h", cyc, {x1, x2, t}, {one.x1, one.x2, one.t}); end
        request = 1'b0; tick();
        checks++; if (epoch !== 16'd1) begin failures++;
            $display("FAIL single_wrap1 epoch=%0d exp=1", epoch); end
        request = 1'b1; wait_dr(cyc);
        request = 1'b0; tick();
`ifdef FEEDER_EPOCH_LIMIT_EN
        checks++; if (timeout !== 1'b1 || busy !== 1'b0) begin failures++;
            $display("FAIL limit_timeout to=%b busy=%b exp=1/0", timeout, busy); end
        request = 1'b1; wait_dr(cyc);
        checks++; if (data_ready !== 1'b0) begin failures++;
            $display("FAIL limit_ignored dr=%b exp=0", data_ready); end
        request = 1'b0;
`else
        checks++; if (epoch !== 16'd2 || busy !== 1'b1) begin failures++;
            $display("FAIL single_wrap2 epoch=%0d busy=%b exp=2/1", epoch, busy); end
`endif
    endtask

    task automatic test_overflow();
        pulse_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 513; i++) begin
            wr_x1 = 7'(i); wr_x2 = 7'(i + 1); wr_t = 2'(i);
            tick();
            if (i == 511) begin
                checks++; if (n_samples !== 32'd512 || overflow !== 1'b0) begin failures++;
                    $display("FAIL fill_512 n=%0d ovf=%b exp=512/0", n_samples, overflow); end
            end
        end
        wr_en = 1'b0;
        checks++; if (n_samples !== 32'd512 || overflow !== 1'b1) begin failures++;
            $display("FAIL overflow n=%0d ovf=%b exp=512/1", n_samples, overflow); end
    endtask

    task automatic test_empty_start();
        pulse_reset();
        start = 1'b1; tick(); start = 1'b0;
        request = 1'b1; tick(); tick(); tick();
        checks++; if (busy !== 1'b0 || data_ready !== 1'b0 || n_samples !== 32'd0) begin failures++;
            $display("FAIL empty_start busy=%b dr=%b n=%0d exp=0/0/0", busy, data_ready, n_samples); end
        request = 1'b0;
    endtask

    initial begin
        vec[0] = '{x1: 7'sd5,  x2: -7'sd3, t: 2'sd1};
        vec[1] = '{x1: -7'sd7, x2: 7'sd2,  t: -2'sd1};
        vec[2] = '{x1: 7'sd0,  x2: 7'sd63, t: 2'sd1};
        one    = '{x1: 7'sd3,  x2: -7'sd1, t: -2'sd2};
        test_reset();
        test_load_first();
        test_stream();
        test_done();
        test_async_rst();
        test_same_cycle_start();
        test_overflow();
        test_empty_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/neuron_sample_feeder.md
Name: neuron_sample_feeder

Overview:
- Upstream stage of the neuron trainer. Buffers the training set (x1, x2, t triples) in an internal RAM.
- Streams the samples to the neuron through its request/dataReady handshake, cycling through the set epoch after epoch until the neuron asserts done.
- Also supplies the neuron's sample-count input.
- Replaces the behavioural sample loop with synthesizable RTL.

Parameters:
- X_W, 7, signed width of x1/x2 samples
- T_W, 2, signed width of target t
- DEPTH, 512, sample RAM entries
- ADDR_W, 9, address width (clog2 DEPTH)
- CNT_W, 32, width of sample count output
- MAX_EPOCHS, 64, epoch limit, used only with the optional feature

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  load strobe, one sample per cycle while in LOAD
- wr_x1  in  X_W  sample x1 to load
- wr_x2  in  X_W  sample x2 to load
- wr_t  in  T_W  sample target to load
- start  in  1  end of load phase, begin streaming
- request  in  1  neuron requests next sample (level)
- neuron_done  in  1  neuron training finished (level)
- x1  out  X_W  presented sample x1
- x2  out  X_W  presented sample x2
- t  out  T_W  presented target
- data_ready  out  1  x1/x2/t valid
- n_samples  out  CNT_W  number of loaded samples
- epoch  out  16  completed passes over the set
- overflow  out  1  sticky; write attempted with RAM full
- busy  out  1  high in all states except LOAD and DONE

Behaviour:
- Reset (async, rst=1): state=LOAD; x1, x2, t, data_ready, n_samples, epoch, overflow, busy all 0; read index=0. RAM contents are not cleared.
- LOAD:
  - wr_en=1 with n_samples<DEPTH: write RAM[n_samples], then n_samples++.
  - wr_en=1 with n_samples==DEPTH: write dropped, overflow<=1.
  - start=1 with n_samples>0 -> WAIT_REQ. start with n_samples==0 is ignored.
  - wr_en and start in the same cycle: the write is performed, then the transition uses the post-write count.
- Outside LOAD: wr_en is ignored and overflow does not change.
- WAIT_REQ: data_ready=0. request=1 -> FETCH.
- FETCH: one-cycle synchronous RAM read of RAM[index] -> PRESENT.
  - x1/x2/t register on entry to PRESENT.
  - data_ready rises exactly 2 cycles after request is first sampled high.
- PRESENT:
  - data_ready=1 and x1/x2/t held stable while request=1.
  - request=0 -> data_ready<=0, then:
    - index<n_samples-1: index++.
    - otherwise: index<=0 and epoch++ (wraps at 2^16).
  - Next state is WAIT_REQ.
- x1/x2/t keep their last value after data_ready falls.
- neuron_done=1 in any of WAIT_REQ/FETCH/PRESENT: next state DONE, data_ready<=0 next cycle. Index and epoch are not advanced for the in-flight sample. neuron_done has priority over request.
- DONE:
  - Outputs hold, data_ready=0.
  - start=1 with neuron_done=0 restarts streaming at index 0 with epoch cleared; the loaded set is retained.
  - Only rst returns to LOAD.
- The request edge is not required: a request held high across WAIT_REQ re-triggers a fetch immediately, so back-to-back samples are allowed.
- rst mid-PRESENT: data_ready drops asynchronously and n_samples clears, so the set must be reloaded.

Optional Feature:
- Macro: FEEDER_EPOCH_LIMIT_EN.
- Defined:
  - Adds output timeout (1 bit, reset 0).
  - When epoch would increment to MAX_EPOCHS: state->DONE, timeout<=1 (sticky until rst), data_ready<=0.
  - Further requests are ignored.
- Undefined: no timeout port; streaming continues until neuron_done.

Decomposition:
- Shared package holds:
  - state enum LOAD/WAIT_REQ/FETCH/PRESENT/DONE
  - default widths X_W, T_W, DEPTH
  - sample record typedef {x1, x2, t}, so the neuron and the feeder agree on widths.
- Sub-module sample_ram: single-port write, single-port synchronous read, DEPTH x (2*X_W+T_W).
- FSM, index/epoch counters and output registers live in the top.

Test Plan:
- Load 3 samples (x1,x2,t) = (5,-3,1), (-7,2,-1), (0,63,1), then start. Hold request until data_ready -> data_ready 2 cycles after request; x1=5, x2=-3, t=1; n_samples=3.
- Pulse request 4 times, each held until data_ready, then dropped -> samples 0,1,2,0 presented in order; epoch=1 after the third drop; data_ready falls one cycle after each request drop.
- Write 513 samples with DEPTH=512 -> n_samples=512, overflow=1; start with an empty set after reset -> state stays LOAD, busy=0.
- Assert neuron_done while in PRESENT with request=1 -> data_ready=0 next cycle, busy=0, epoch unchanged. Later start -> streaming resumes from sample 0 with epoch=0.
- Assert rst for 1 cycle while data_ready=1 -> data_ready, n_samples, epoch all 0 immediately; state LOAD.
- With FEEDER_EPOCH_LIMIT_EN and MAX_EPOCHS=2, load 1 sample and service requests continuously -> after the 2nd wrap timeout=1, DONE, further requests get no data_ready.
